model_vertex_transform: RTL and testbench
=========================================

Name: model_vertex_transform

Overview:
- Sequential affine transform stage directly downstream of the model-matrix generator.
- Takes the 4x4 Q8.8 model matrix and one object-space vertex (x, y, z), then produces the world-space vertex (x', y', z').
- Uses a single shared signed multiplier, time-multiplexed over 9 MAC cycles, behind valid/ready handshakes on both sides.
- Feeds the view/projection stage.

Parameters:
- WI, 8, integer bits of all signed fixed-point operands and results.
- WF, 8, fraction bits of all operands and results; word width is WI+WF = 16.
- GUARD, 4, extra accumulator MSBs above the 2*(WI+WF) product width.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  vertex and matrix present.
- in_ready  output  1  block can accept a vertex.
- vertex_x, vertex_y, vertex_z  input  16 each  signed Q8.8 object-space coordinates.
- model_matrix  input  [15:0][15:0]  row-major entries; index 4*r+c; Q8.8 signed.
- out_valid  output  1  result held valid.
- out_ready  input  1  downstream accepts result.
- out_x, out_y, out_z  output  16 each  signed Q8.8 transformed coordinates.
- out_overflow  output  3  per-component saturation flags; bit0=x, bit1=y, bit2=z.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is a synchronous, active-high input sampled on the Clk edge, with precedence over all other inputs. After reset:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - out_x/out_y/out_z = 0; out_overflow = 0; accumulator and counters cleared.
- States: IDLE, MAC, DONE.
- IDLE: in_ready = 1.
  - On in_valid && in_ready, latch the vertex, matrix entries 0-11 and translations (entries 3, 7, 11). Go to MAC with k = 0.
  - Entries 12-15 are ignored; the matrix is treated as affine with w = 1.
- MAC: one product per cycle, k = 0..8, with row r = k/3 and column c = k%3.
  - At c = 0, load the accumulator with sign_extend(m[4r+3]) << WF, plus product m[4r+c]*v[c]. Otherwise accumulate the product.
  - Product is a full 32-bit signed Q16.16. Accumulator is 32+GUARD bits.
  - At c = 2, the completed row sum (accumulator plus that cycle's product) is rounded half-up: (sum + 2^(WF-1)) >>> WF, arithmetic shift.
  - The rounded value saturates to the range 0x8000..0x7FFF and is written to out_x/out_y/out_z for r = 0/1/2. out_overflow[r] = 1 if clipped, else 0.
  - After k = 8, go to DONE.
- DONE: out_valid = 1 and in_ready = 0.
  - Outputs hold stable while out_ready = 0; there is no timeout.
  - On out_ready = 1, go to IDLE; out_valid drops on the next cycle.
  - Outputs keep their last values in IDLE, but are meaningful only while out_valid = 1.
- Latency: the accept cycle is T. MAC runs in T+1..T+9. out_valid is first high in T+10.
- Minimum vertex spacing is 11 cycles with out_ready held high. There is no accept in the same cycle as the DONE handoff.
- in_valid is ignored outside IDLE. Matrix and vertex inputs may change freely after the accept cycle without affecting the in-flight result.
- Reset mid-operation (MAC or DONE) aborts the vertex with no output, and the block returns to the reset state on the following cycle.
- Simultaneous Reset and in_valid: Reset wins and the vertex is not accepted.

Test Plan:
- Identity matrix (diagonal 0x0100, translations 0), vertex (0x0180, 0xFF00, 0x0040) -> out = (0x0180, 0xFF00, 0x0040), overflow = 0, out_valid first high exactly 10 cycles after the accept cycle.
- Scale/translate: m0 = m5 = m10 = 0x0280 (2.5), m3 = 0x0100, m7 = 0xFF80, vertex (0x0200, 0x0100, 0) -> out = (0x0600, 0x0200, 0x0000).
- 90° Y rotation: m0 = m10 = 0, m2 = 0x0100, m8 = 0xFF00, m5 = 0x0100, vertex (0x0100, 0, 0) -> out = (0x0000, 0x0000, 0xFF00).
- Rounding and saturation:
  - m0 = 0x0001, vertex_x = 0x0080 -> out_x = 0x0001.
  - m0 = 0x7FFF, vertex_x = 0x7FFF -> out_x = 0x7FFF, out_overflow[0] = 1.
  - m0 = 0x8000, vertex_x = 0x7FFF -> out_x = 0x8000, out_overflow[0] = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with new data -> outputs unchanged, in_ready = 0, no new accept. Then raise out_ready -> IDLE next cycle, and the next vertex is accepted the cycle after.
- Reset asserted at MAC k = 4 -> next cycle out_valid = 0, in_ready = 1, outputs = 0. A vertex presented afterwards completes with correct latency (10 cycles).

Source files
------------

// File: rtl/model_vertex_transform.sv
// Affine model-space to world-space vertex transform, Q(WI).(WF) fixed point.
// One shared signed multiplier runs nine MAC cycles per vertex behind valid/ready handshakes.
module model_vertex_transform #(
  parameter int unsigned WI    = 8,
  parameter int unsigned WF    = 8,
  parameter int unsigned GUARD = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WI+WF-1:0]            vertex_x,
  input  logic [WI+WF-1:0]            vertex_y,
  input  logic [WI+WF-1:0]            vertex_z,
  input  logic [15:0][WI+WF-1:0]      model_matrix,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WI+WF-1:0]            out_x,
  output logic [WI+WF-1:0]            out_y,
  output logic [WI+WF-1:0]            out_z,
  output logic [2:0]                  out_overflow,
  output logic                        busy
);

  localparam int unsigned W    = WI + WF;
  localparam int unsigned AccW = 2 * W + GUARD;

  localparam logic [AccW-1:0] RndHalf = {{(AccW - WF){1'b0}}, 1'b1, {(WF - 1){1'b0}}};
  localparam logic [W-1:0]    SatMax  = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]    SatMin  = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             row_q, row_d;
  logic [1:0]             col_q, col_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [W-1:0]           vec_q [3];
  logic [W-1:0]           vec_d [3];
  logic [W-1:0]           mat_q [12];
  logic [W-1:0]           mat_d [12];
  logic [W-1:0]           res_q [3];
  logic [W-1:0]           res_d [3];
  logic [2:0]             ovf_q, ovf_d;

  // Bottom row of the matrix is implied (0 0 0 1).
  logic unused_bottom_row;
  assign unused_bottom_row = ^{model_matrix[15], model_matrix[14], model_matrix[13],
                               model_matrix[12]};

  // Datapath: one product per cycle, row seeded by its translation term.
  logic [3:0]             mat_idx;
  logic [W-1:0]           mat_sel;
  logic [W-1:0]           vec_sel;
  logic [W-1:0]           trans_sel;
  logic signed [2*W-1:0]  prod;
  logic signed [AccW-1:0] prod_ext;
  logic signed [AccW-1:0] trans_ext;
  logic signed [AccW-1:0] acc_base;
  logic signed [AccW-1:0] sum;
  logic signed [AccW-1:0] rnd_sum;
  logic signed [AccW-1:0] rounded;
  logic [AccW-W:0]        rnd_hi;
  logic                   clip;
  logic [W-1:0]           sat_val;

  assign mat_idx   = {row_q, 2'b00} + {2'b00, col_q};
  assign mat_sel   = mat_q[mat_idx];
  assign vec_sel   = vec_q[col_q];
  assign trans_sel = mat_q[{row_q, 2'b11}];

  assign prod      = $signed({{W{mat_sel[W-1]}}, mat_sel}) * $signed({{W{vec_sel[W-1]}}, vec_sel});
  assign prod_ext  = $signed({{GUARD{prod[2*W-1]}}, prod});
  assign trans_ext = $signed({{(WI + GUARD){trans_sel[W-1]}}, trans_sel, {WF{1'b0}}});
  assign acc_base  = (col_q == 2'd0) ? trans_ext : acc_q;
  assign sum       = acc_base + prod_ext;

  // Round half-up, then clip to the signed output word range.
  assign rnd_sum   = sum + $signed(RndHalf);
  assign rounded   = rnd_sum >>> WF;
  assign rnd_hi    = rounded[AccW-1:W-1];
  assign clip      = !((&rnd_hi) || !(|rnd_hi));
  assign sat_val   = clip ? (rounded[AccW-1] ? SatMin : SatMax) : rounded[W-1:0];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    mat_d   = mat_q;
    res_d   = res_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          vec_d[0] = vertex_x;
          vec_d[1] = vertex_y;
          vec_d[2] = vertex_z;
          for (int i = 0; i < 12; i++) begin
            mat_d[i] = model_matrix[i];
          end
          row_d   = 2'd0;
          col_d   = 2'd0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = sum;
        if (col_q == 2'd2) begin
          res_d[row_q] = sat_val;
          ovf_d[row_q] = clip;
          col_d        = 2'd0;
          if (row_q == 2'd2) begin
            row_d   = 2'd0;
            state_d = StDone;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      vec_q   <= '{default: '0};
      mat_q   <= '{default: '0};
      res_q   <= '{default: '0};
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      mat_q   <= mat_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign out_x        = res_q[0];
  assign out_y        = res_q[1];
  assign out_z        = res_q[2];
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_model_vertex_transform.sv
// Bench for model_vertex_transform: directed cases plus randomized back-to-back traffic
// checked against an integer reference model.
module tb_model_vertex_transform;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       vertex_x = '0, vertex_y = '0, vertex_z = '0;
  logic [15:0][15:0] mm = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       out_x, out_y, out_z;
  logic [2:0]        out_overflow;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  model_vertex_transform dut (
    .Clk          (clk),
    .Reset        (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .vertex_x     (vertex_x),
    .vertex_y     (vertex_y),
    .vertex_z     (vertex_z),
    .model_matrix (mm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_z        (out_z),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: world = M[0:2][0:2] * v + t, rounded half-up and clipped to 16 bits.
  function automatic void model(input logic [15:0][15:0] m, input logic [15:0] vx, vy, vz,
                                output logic [2:0][15:0] res, output logic [2:0] ovf);
    logic [2:0][15:0] v;
    longint s;
    v = {vz, vy, vx};
    for (int r = 0; r < 3; r++) begin
      s = longint'($signed(m[4*r+3])) * 256;
      for (int c = 0; c < 3; c++) begin
        s += longint'($signed(m[4*r+c])) * longint'($signed(v[c]));
      end
      s = (s + 128) >>> 8;
      if (s > 32767) begin
        res[r] = 16'h7FFF; ovf[r] = 1'b1;
      end else if (s < -32768) begin
        res[r] = 16'h8000; ovf[r] = 1'b1;
      end else begin
        res[r] = s[15:0];  ovf[r] = 1'b0;
      end
    end
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    if ($urandom_range(0, 1) == 1) begin
      w = 16'($urandom);
    end else begin
      w = 16'($urandom_range(0, 2047));
      w = w - 16'd1024;
    end
    return w;
  endfunction

  task automatic apply(input logic [15:0][15:0] m, input logic [15:0] x, y, z);
    mm = m; vertex_x = x; vertex_y = y; vertex_z = z;
  endtask

  task automatic scramble();
    logic [15:0][15:0] m;
    for (int i = 0; i < 16; i++) m[i] = rnd_word();
    apply(m, rnd_word(), rnd_word(), rnd_word());
  endtask

  // Called just after the accept edge; lat counts cycles from the accept cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send(input logic [15:0][15:0] m, input logic [15:0] x, y, z, output int lat);
    apply(m, x, y, z);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    wait_done(lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if ({out_x, out_y, out_z, out_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %h ovf=%b, want zeros",
               out_x, out_y, out_z, out_overflow);
    end
  endtask

  task automatic test_identity();
    logic [15:0][15:0] m;
    int lat;
    m = '0;
    m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
    send(m, 16'h0180, 16'hFF00, 16'h0040, lat);
    checks++;
    if (out_valid !== 1'b1 || lat != 10) begin
      errors++;
      $display("FAIL identity_latency: lat=%0d valid=%b, want 10 1", lat, out_valid);
    end
    checks++;
    if ({out_x, out_y, out_z, out_overflow} !== {16'h0180, 16'hFF00, 16'h0040, 3'b000}) begin
      errors++;
      $display("FAIL identity_value: got %h %h %h ovf=%b, want 0180 ff00 0040 000",
               out_x, out_y, out_z, out_overflow);
    end
    release_out();
  endtask

  task automatic test_scale_translate();
    logic [15:0][15:0] m;
    int lat;
    m = '0;
    m[0] = 16'h0280; m[5] = 16'h0280; m[10] = 16'h0280;
    m[3] = 16'h0100; m[7] = 16'hFF80;
    send(m, 16'h0200, 16'h0100, 16'h0000, lat);
    checks++;
    if (out_valid !== 1'b1 ||
        {out_x, out_y, out_z, out_overflow} !== {16'h0600, 16'h0200, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL scale_translate: got %h %h %h ovf=%b valid=%b, want 0600 0200 0000 000 1",
               out_x, out_y, out_z, out_overflow, out_valid);
    end
    release_out();
  endtask

  task automatic test_rotation();
    logic [15:0][15:0] m;
    int lat;
    m = '0;
    m[2] = 16'h0100; m[8] = 16'hFF00; m[5] = 16'h0100;
    send(m, 16'h0100, 16'h0000, 16'h0000, lat);
    checks++;
    if (out_valid !== 1'b1 ||
        {out_x, out_y, out_z, out_overflow} !== {16'h0000, 16'h0000, 16'hFF00, 3'b000}) begin
      errors++;
      $display("FAIL rotation_y90: got %h %h %h ovf=%b valid=%b, want 0000 0000 ff00 000 1",
               out_x, out_y, out_z, out_overflow, out_valid);
    end
    release_out();
  endtask

  task automatic test_round_saturate();
    logic [15:0] tm [3];
    logic [15:0] tv [3];
    logic [15:0] tx [3];
    logic        to [3];
    logic [15:0][15:0] m;
    int lat;
    tm = '{16'h0001, 16'h7FFF, 16'h8000};
    tv = '{16'h0080, 16'h7FFF, 16'h7FFF};
    tx = '{16'h0001, 16'h7FFF, 16'h8000};
    to = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      m = '0;
      m[0] = tm[i];
      send(m, tv[i], 16'h0000, 16'h0000, lat);
      checks++;
      if (out_valid !== 1'b1 || out_x !== tx[i] || out_overflow !== {2'b00, to[i]}) begin
        errors++;
        $display("FAIL round_sat[%0d]: out_x=%h ovf=%b valid=%b, want %h %b 1",
                 i, out_x, out_overflow, out_valid, tx[i], {2'b00, to[i]});
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0][15:0] ma, mb;
    logic [15:0] bx, by, bz;
    logic [2:0][15:0] ra, rb;
    logic [2:0] oa, ob;
    int lat;
    for (int i = 0; i < 16; i++) begin
      ma[i] = rnd_word();
      mb[i] = rnd_word();
    end
    bx = rnd_word(); by = rnd_word(); bz = rnd_word();
    model(ma, 16'h0123, 16'hFEDC, 16'h0777, ra, oa);
    model(mb, bx, by, bz, rb, ob);
    send(ma, 16'h0123, 16'hFEDC, 16'h0777, lat);
    apply(mb, bx, by, bz);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_z, out_y, out_x, out_overflow} !== {ra, oa}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b in_ready=%b got %h %h %h %b, want %h %b",
                 i, out_valid, in_ready, out_x, out_y, out_z, out_overflow, ra, oa);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_accept: busy=%b, want 1", busy);
    end
    wait_done(lat);
    checks++;
    if (out_valid !== 1'b1 || lat != 10 || {out_z, out_y, out_x, out_overflow} !== {rb, ob}) begin
      errors++;
      $display("FAIL backpressure_next: lat=%0d got %h %h %h %b, want 10 %h %b",
               lat, out_x, out_y, out_z, out_overflow, rb, ob);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [15:0][15:0] m;
    logic [2:0][15:0] r;
    logic [2:0] o;
    int lat;
    m = '0;
    m[0] = 16'h0300; m[3] = 16'h0500; m[5] = 16'h0200; m[10] = 16'h0100;
    apply(m, 16'h0100, 16'h0100, 16'h0100);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        {out_x, out_y, out_z, out_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b in_ready=%b busy=%b out %h %h %h %b, want 0 1 0 zeros",
               out_valid, in_ready, busy, out_x, out_y, out_z, out_overflow);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    for (int i = 0; i < 16; i++) m[i] = rnd_word();
    model(m, 16'h0040, 16'hFFC0, 16'h0200, r, o);
    send(m, 16'h0040, 16'hFFC0, 16'h0200, lat);
    checks++;
    if (out_valid !== 1'b1 || lat != 10 || {out_z, out_y, out_x, out_overflow} !== {r, o}) begin
      errors++;
      $display("FAIL reset_mid_recover: lat=%0d got %h %h %h %b, want 10 %h %b",
               lat, out_x, out_y, out_z, out_overflow, r, o);
    end
    release_out();
  endtask

  task automatic test_reset_vs_valid();
    scramble();
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_vs_valid: busy=%b in_ready=%b, want 0 1", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 16;
    logic [50:0] exp_q [$];
    int acc_cyc [$];
    logic [15:0][15:0] m;
    logic [15:0] x, y, z;
    logic [2:0][15:0] r;
    logic [2:0] o;
    logic [50:0] e;
    int sent, got, cyc, prev_acc, a;
    sent = 0; got = 0; cyc = 0; prev_acc = -1;
    out_ready = 1'b1;
    while (got < N && cyc < 600) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: output at cycle %0d with nothing pending", cyc);
        end else begin
          e = exp_q.pop_front();
          a = acc_cyc.pop_front();
          if ({out_z, out_y, out_x, out_overflow} !== e || cyc - a != 10) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h %h %h %b lat=%0d, want %h lat=10",
                     got, out_x, out_y, out_z, out_overflow, cyc - a, e);
          end
        end
        got++;
      end
      for (int i = 0; i < 16; i++) m[i] = rnd_word();
      x = rnd_word(); y = rnd_word(); z = rnd_word();
      apply(m, x, y, z);
      in_valid = (sent < N);
      if (in_valid && in_ready === 1'b1) begin
        model(m, x, y, z, r, o);
        exp_q.push_back({r, o});
        acc_cyc.push_back(cyc);
        if (prev_acc >= 0) begin
          checks++;
          if (cyc - prev_acc != 11) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 11", sent, cyc - prev_acc);
          end
        end
        prev_acc = cyc;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != N) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want %0d", got, N);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_scale_translate();
    test_rotation();
    test_round_saturate();
    test_backpressure();
    test_reset_mid();
    test_reset_vs_valid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
